// File: rtl/zap_memory_store_pkg.sv
// Shared types and constants for the store data path.
// Holds the FSM state encoding, the store size codes, the byte-select constants,
// the registered bus request payload and the size decode helper.
package zap_memory_store_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  localparam logic [SEL_W-1:0] SEL_B0      = 4'b0001;
  localparam logic [SEL_W-1:0] SEL_LO_HALF = 4'b0011;
  localparam logic [SEL_W-1:0] SEL_HI_HALF = 4'b1100;
  localparam logic [SEL_W-1:0] SEL_WORD    = 4'b1111;

  typedef struct packed {
    logic [WORD_W-1:0] adr;
    logic [WORD_W-1:0] dat;
    logic [SEL_W-1:0]  sel;
  } wb_req_t;

  // Byte has priority over half, half over word.
  function automatic size_t size_decode(input logic ubyte, input logic sbyte,
                                        input logic uhalf, input logic shalf);
    if (ubyte | sbyte) return SZ_BYTE;
    if (uhalf | shalf) return SZ_HALF;
    return SZ_WORD;
  endfunction

endpackage

// File: rtl/zap_memory_store_if.sv
// Wishbone-classic write-side bus between the store unit and memory.
// master: store unit (drives stb/cyc/we/adr/dat/sel, receives ack/err).
// slave : memory side.
interface zap_memory_store_if;
  import zap_memory_store_pkg::*;

  logic              o_wb_stb;
  logic              o_wb_cyc;
  logic              o_wb_we;
  logic [WORD_W-1:0] o_wb_adr;
  logic [WORD_W-1:0] o_wb_dat;
  logic [SEL_W-1:0]  o_wb_sel;
  logic              i_wb_ack;
  logic              i_wb_err;

  modport master (
    output o_wb_stb, o_wb_cyc, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel,
    input  i_wb_ack, i_wb_err
  );

  modport slave (
    input  o_wb_stb, o_wb_cyc, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel,
    output i_wb_ack, i_wb_err
  );
endinterface

// File: rtl/zap_store_lane_gen.sv
// Combinational lane generator: replicates store data across byte lanes and
// builds byte selects from the low address bits and the store size.
// Ports: i_addr_lo (addr[1:0]), i_size, i_data -> o_dat, o_sel, o_misaligned.
// ZAP_STORE_ALIGN_CHECK_EN: when defined, o_misaligned flags a half store on an
// odd address or a word store not on a word boundary; otherwise it is tied 0.
module zap_store_lane_gen
  import zap_memory_store_pkg::*;
(
  input  logic [1:0]        i_addr_lo,
  input  size_t             i_size,
  input  logic [WORD_W-1:0] i_data,
  output logic [WORD_W-1:0] o_dat,
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_misaligned
);

  // Lane replication and byte selects.
  always_comb begin
    o_dat = i_data;
    o_sel = SEL_WORD;
    case (i_size)
      SZ_BYTE: begin
        o_dat = {4{i_data[7:0]}};
        o_sel = SEL_B0 << i_addr_lo;
      end
      SZ_HALF: begin
        o_dat = {2{i_data[15:0]}};
        o_sel = i_addr_lo[1] ? SEL_HI_HALF : SEL_LO_HALF;
      end
      default: begin
        o_dat = i_data;
        o_sel = SEL_WORD;
      end
    endcase
  end

`ifdef ZAP_STORE_ALIGN_CHECK_EN
  // Alignment detect; bytes can never be misaligned.
  always_comb begin
    o_misaligned = 1'b0;
    case (i_size)
      SZ_BYTE: o_misaligned = 1'b0;
      SZ_HALF: o_misaligned = i_addr_lo[0];
      default: o_misaligned = |i_addr_lo;
    endcase
  end
`else
  assign o_misaligned = 1'b0;
`endif

endmodule

// File: rtl/zap_memory_store.sv
// Store unit: accepts a store from the ALU stage and runs one Wishbone-classic
// write cycle per store, stalling the pipeline while the cycle is outstanding.
// Ports: i_clk, i_reset_n (async active-low), i_clear_from_writeback (flush),
//   i_dav_ff/i_mem_store_ff (store valid), i_mem_address_ff, i_mem_srcdest_value_ff,
//   i_ubyte_ff/i_sbyte_ff/i_uhalf_ff/i_shalf_ff (size), wb (bus master),
//   o_data_stall (busy), o_mem_fault (one-cycle bus fault pulse).
// Parameter TIMEOUT_CYCLES: busy cycles without ack/err before a fault is forced.
// Macro ZAP_STORE_ALIGN_CHECK_EN: reject misaligned half/word stores with a fault.
module zap_memory_store
  import zap_memory_store_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clear_from_writeback,
  input  logic              i_dav_ff,
  input  logic              i_mem_store_ff,
  input  logic [WORD_W-1:0] i_mem_address_ff,
  input  logic [WORD_W-1:0] i_mem_srcdest_value_ff,
  input  logic              i_ubyte_ff,
  input  logic              i_sbyte_ff,
  input  logic              i_uhalf_ff,
  input  logic              i_shalf_ff,
  zap_memory_store_if.master wb,
  output logic              o_data_stall,
  output logic              o_mem_fault
);

  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              kill_q, kill_d;
  logic              stb_q, stb_d;
  logic              fault_q, fault_d;
  wb_req_t           req_q, req_d;

  size_t             size_c;
  logic [WORD_W-1:0] lane_dat_c;
  logic [SEL_W-1:0]  lane_sel_c;
  logic              misaligned_c;
  logic              accept_c;
  logic              term_c;

  assign size_c = size_decode(i_ubyte_ff, i_sbyte_ff, i_uhalf_ff, i_shalf_ff);

  zap_store_lane_gen u_lane_gen (
    .i_addr_lo    (i_mem_address_ff[1:0]),
    .i_size       (size_c),
    .i_data       (i_mem_srcdest_value_ff),
    .o_dat        (lane_dat_c),
    .o_sel        (lane_sel_c),
    .o_misaligned (misaligned_c)
  );

  assign accept_c = (state_q == ST_IDLE) & i_dav_ff & i_mem_store_ff & ~i_clear_from_writeback;
  // Ack/err take priority over the timeout when they land on the last cycle.
  assign term_c   = wb.i_wb_ack | wb.i_wb_err | (cnt_q == CNT_LAST);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    stb_d   = stb_q;
    req_d   = req_q;
    fault_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        kill_d = 1'b0;
        if (accept_c) begin
          if (misaligned_c) begin
            fault_d = 1'b1;
          end else begin
            state_d   = ST_BUSY;
            stb_d     = 1'b1;
            cnt_d     = '0;
            req_d.adr = {i_mem_address_ff[WORD_W-1:2], 2'b00};
            req_d.dat = lane_dat_c;
            req_d.sel = lane_sel_c;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A flushed cycle still completes on the bus; only its fault is dropped.
        if (i_clear_from_writeback) kill_d = 1'b1;
        if (term_c) begin
          state_d = ST_IDLE;
          stb_d   = 1'b0;
          cnt_d   = '0;
          kill_d  = 1'b0;
          fault_d = (wb.i_wb_err | ~wb.i_wb_ack) & ~(kill_q | i_clear_from_writeback);
        end
      end
      default: begin
        state_d = ST_IDLE;
        stb_d   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      stb_q   <= 1'b0;
      fault_q <= 1'b0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      stb_q   <= stb_d;
      fault_q <= fault_d;
      req_q   <= req_d;
    end
  end

  assign wb.o_wb_stb  = stb_q;
  assign wb.o_wb_cyc  = stb_q;
  assign wb.o_wb_we   = stb_q;
  assign wb.o_wb_adr  = req_q.adr;
  assign wb.o_wb_dat  = req_q.dat;
  assign wb.o_wb_sel  = req_q.sel;
  assign o_data_stall = (state_q == ST_BUSY);
  assign o_mem_fault  = fault_q;

endmodule

// File: tb/tb_zap_memory_store.sv
// Self-checking bench for zap_memory_store: directed cases plus randomized stores
// compared against a transaction-level reference model.
module tb_zap_memory_store;

  localparam int unsigned TMO = 4;
`ifdef ZAP_STORE_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        dav;
  logic        store;
  logic [31:0] addr;
  logic [31:0] data;
  logic        ub, sb, uh, sh;
  logic        stall;
  logic        fault;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  zap_memory_store_if bus ();

  zap_memory_store #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk                  (clk),
    .i_reset_n              (rst_n),
    .i_clear_from_writeback (clear),
    .i_dav_ff               (dav),
    .i_mem_store_ff         (store),
    .i_mem_address_ff       (addr),
    .i_mem_srcdest_value_ff (data),
    .i_ubyte_ff             (ub),
    .i_sbyte_ff             (sb),
    .i_uhalf_ff             (uh),
    .i_shalf_ff             (sh),
    .wb                     (bus.master),
    .o_data_stall           (stall),
    .o_mem_fault            (fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: flags = {ubyte, sbyte, uhalf, shalf}.
  function automatic int size_of(input logic [3:0] flags);
    if (flags[3] || flags[2]) return 1;
    if (flags[1] || flags[0]) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_dat(input int bytes, input logic [31:0] d);
    if (bytes == 1) return (d & 32'h0000_00FF) * 32'h0101_0101;
    if (bytes == 2) return (d & 32'h0000_FFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] exp_sel(input int bytes, input logic [31:0] a);
    int s;
    if (bytes == 1) begin
      s = 1 << (a % 4);
      return 4'(s);
    end
    if (bytes == 2) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic bit exp_misaligned(input int bytes, input logic [31:0] a);
    if (!ALIGN_EN) return 1'b0;
    return (a % bytes) != 0;
  endfunction

  task automatic idle_inputs();
    dav = 1'b0; store = 1'b0; clear = 1'b0;
    ub = 1'b0; sb = 1'b0; uh = 1'b0; sh = 1'b0;
    bus.i_wb_ack = 1'b0; bus.i_wb_err = 1'b0;
  endtask

  // One store; entered and left at a negedge with the DUT idle.
  // lat: busy cycle in which ack/err is raised; flush_k: busy cycle of a flush (0 = none).
  task automatic run_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] flags, input int lat, input bit use_err,
                           input int flush_k);
    int          bytes;
    int          term_k;
    int          stalls;
    bit          killed;
    bit          exp_fault;
    logic [31:0] e_adr;
    logic [31:0] e_dat;
    logic [3:0]  e_sel;
    bytes  = size_of(flags);
    e_adr  = a & 32'hFFFF_FFFC;
    e_dat  = exp_dat(bytes, d);
    e_sel  = exp_sel(bytes, a);
    stalls = 0;
    chk({tag, ".pre_stall"}, 32'(stall), 32'd0);
    dav = 1'b1; store = 1'b1; clear = 1'b0;
    addr = a; data = d;
    {ub, sb, uh, sh} = flags;
    if (exp_misaligned(bytes, a)) begin
      @(negedge clk);
      dav = 1'b0; store = 1'b0;
      chk({tag, ".mis_stb"}, 32'(bus.o_wb_stb), 32'd0);
      chk({tag, ".mis_stall"}, 32'(stall), 32'd0);
      chk({tag, ".mis_fault"}, 32'(fault), 32'd1);
      @(negedge clk);
      chk({tag, ".mis_fault_end"}, 32'(fault), 32'd0);
      return;
    end
    term_k    = (lat <= int'(TMO)) ? lat : int'(TMO);
    exp_fault = use_err || (lat > int'(TMO));
    killed    = (flush_k >= 1) && (flush_k <= term_k);
    for (int k = 1; k <= term_k; k++) begin
      @(negedge clk);
      bus.i_wb_ack = 1'b0; bus.i_wb_err = 1'b0; clear = 1'b0;
      if (stall) stalls++;
      chk({tag, ".stb"}, 32'(bus.o_wb_stb), 32'd1);
      chk({tag, ".fault_busy"}, 32'(fault), 32'd0);
      if (k == 1) begin
        chk({tag, ".cyc"}, 32'(bus.o_wb_cyc), 32'd1);
        chk({tag, ".we"}, 32'(bus.o_wb_we), 32'd1);
        chk({tag, ".dat"}, bus.o_wb_dat, e_dat);
        chk({tag, ".sel"}, 32'(bus.o_wb_sel), 32'(e_sel));
      end
      chk({tag, ".adr"}, bus.o_wb_adr, e_adr);
      if (k == lat) begin
        bus.i_wb_err = use_err;
        bus.i_wb_ack = use_err ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (k == flush_k) clear = 1'b1;
    end
    @(negedge clk);
    bus.i_wb_ack = 1'b0; bus.i_wb_err = 1'b0; clear = 1'b0;
    dav = 1'b0; store = 1'b0;
    chk({tag, ".stb_drop"}, 32'(bus.o_wb_stb), 32'd0);
    chk({tag, ".stall_end"}, 32'(stall), 32'd0);
    chk({tag, ".fault"}, 32'(fault), 32'(exp_fault && !killed));
    chk({tag, ".stall_cycles"}, 32'(stalls), 32'(term_k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rd;
    logic [3:0]  rf;
    int          rlat, rflush;
    bit          rerr;
    idle_inputs();
    addr = '0; data = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.stb", 32'(bus.o_wb_stb), 32'd0);
    chk("rst.cyc", 32'(bus.o_wb_cyc), 32'd0);
    chk("rst.we", 32'(bus.o_wb_we), 32'd0);
    chk("rst.adr", bus.o_wb_adr, 32'd0);
    chk("rst.dat", bus.o_wb_dat, 32'd0);
    chk("rst.sel", 32'(bus.o_wb_sel), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_store("byte", 32'h0000_1003, 32'h0000_00A5, 4'b1000, 2, 1'b0, 0);
    run_store("half", 32'h0000_2002, 32'h0000_BEEF, 4'b0010, 4, 1'b0, 0);
    run_store("werr", 32'h0000_3000, 32'h1234_5678, 4'b0000, 1, 1'b1, 0);
    run_store("b2b0", 32'h0000_3004, 32'hCAFE_F00D, 4'b0000, 1, 1'b0, 0);
    run_store("b2b1", 32'h0000_3008, 32'hDEAD_BEEF, 4'b0000, 1, 1'b0, 0);
    run_store("tmo", 32'h0000_5000, 32'h0000_0001, 4'b0000, 100, 1'b0, 0);
    run_store("tmo_flush", 32'h0000_5004, 32'h0000_0002, 4'b0000, 100, 1'b0, 2);
    run_store("err_flush", 32'h0000_5008, 32'h0000_0003, 4'b0000, 3, 1'b1, 3);
    run_store("prio", 32'h0000_6002, 32'h0000_1177, 4'b0111, 1, 1'b0, 0);
    run_store("mis_word", 32'h0000_4001, 32'h0BAD_0BAD, 4'b0000, 1, 1'b0, 0);
    run_store("mis_half", 32'h0000_4003, 32'h0000_5A5A, 4'b0001, 2, 1'b0, 0);

    // Flush in IDLE: store is dropped.
    dav = 1'b1; store = 1'b1; clear = 1'b1; addr = 32'h0000_7000;
    @(negedge clk);
    idle_inputs();
    chk("idle_flush.stb", 32'(bus.o_wb_stb), 32'd0);
    chk("idle_flush.stall", 32'(stall), 32'd0);
    // Valid non-store: no bus activity.
    dav = 1'b1; store = 1'b0;
    @(negedge clk);
    idle_inputs();
    chk("nonstore.stb", 32'(bus.o_wb_stb), 32'd0);
    chk("nonstore.stall", 32'(stall), 32'd0);

    // Reset in the middle of a bus cycle.
    dav = 1'b1; store = 1'b1; addr = 32'h0000_8000; data = 32'h1111_2222;
    @(negedge clk);
    chk("rst_mid.stb_before", 32'(bus.o_wb_stb), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.stb_async", 32'(bus.o_wb_stb), 32'd0);
    chk("rst_mid.stall", 32'(stall), 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid.fault", 32'(fault), 32'd0);
    chk("rst_mid.stb_after", 32'(bus.o_wb_stb), 32'd0);

    // Randomized stores.
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rd = $urandom;
      case ($urandom_range(0, 2))
        0:       rf = 4'($urandom_range(4, 15));
        1:       rf = 4'($urandom_range(1, 3));
        default: rf = 4'b0000;
      endcase
      rlat   = int'($urandom_range(1, 6));
      rerr   = ($urandom_range(0, 4) == 0);
      rflush = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      run_store("rnd", ra, rd, rf, rlat, rerr, rflush);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
